// File: rtl/btn_debounce.sv
// btn_debounce
//
// Conditions up to N raw push-button/switch pins into clean debounced levels
// plus single-cycle press/release event pulses. Each bit is handled by its own
// independent slice: a two-flop synchronizer, a debounce counter that must see
// DEBOUNCE_CYCLES consecutive disagreeing samples before accepting a new level,
// and a registered edge detector.
//
// Optional feature, enabled by defining the macro BTN_AUTOREPEAT_EN:
//   while a button stays pressed, out_pressed re-fires REPEAT_DELAY cycles
//   after the accepted press and then every REPEAT_PERIOD cycles until release.
//   Without the macro no repeat logic exists and REPEAT_* are ignored.
//
// Ports:
//   clock        in  1  sole clock, rising edge
//   reset        in  1  synchronous, active-low
//   in_btns      in  N  raw asynchronous button levels, 1 = pressed
//   out_btns     out N  debounced level per bit
//   out_pressed  out N  one-cycle pulse on accepted press (and on repeats)
//   out_released out N  one-cycle pulse on accepted release

module btn_debounce #(
    parameter int N               = 8,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] in_btns,
    output logic [N-1:0] out_btns,
    output logic [N-1:0] out_pressed,
    output logic [N-1:0] out_released
);

    // The counter only has to hold 0 .. DEBOUNCE_CYCLES-1.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
    // The repeat counter restarts at every event, so it never needs to hold
    // more than the larger of the two intervals minus one.
    localparam int R_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW    = (R_MAX > 1) ? $clog2(R_MAX) : 1;
    localparam logic [RW-1:0] R_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] R_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
`endif

    // Reject nonsensical timing parameters at elaboration.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("btn_debounce: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    for (genvar i = 0; i < N; i++) begin : g_bit
        logic          s1;
        logic          s2;
        logic          level;
        logic          pressed;
        logic          released;
        logic [CW-1:0] cnt;
        logic          accept;

        // The synchronized level has disagreed with the accepted level for the
        // full debounce window, so this edge commits the new level.
        assign accept = (s2 != level) && (cnt == C_LAST);

`ifdef BTN_AUTOREPEAT_EN
        logic [RW-1:0] rpt;
        logic          rpt_periodic;
`endif

        always_ff @(posedge clock) begin
            if (!reset) begin
                s1       <= 1'b0;
                s2       <= 1'b0;
                level    <= 1'b0;
                pressed  <= 1'b0;
                released <= 1'b0;
                cnt      <= '0;
`ifdef BTN_AUTOREPEAT_EN
                rpt          <= '0;
                rpt_periodic <= 1'b0;
`endif
            end else begin
                s1       <= in_btns[i];
                s2       <= s1;
                pressed  <= 1'b0;
                released <= 1'b0;

                // Any agreeing sample restarts the window from zero.
                if (s2 == level) begin
                    cnt <= '0;
                end else if (!accept) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    level    <= s2;
                    cnt      <= '0;
                    pressed  <= s2;
                    released <= !s2;
                end

`ifdef BTN_AUTOREPEAT_EN
                // An accepted edge (press or release) or an idle button clears
                // the repeat timer; a coincident repeat is therefore dropped in
                // favour of the release.
                if (!level || accept) begin
                    rpt          <= '0;
                    rpt_periodic <= 1'b0;
                end else if (rpt == (rpt_periodic ? R_PERIOD_LAST : R_DELAY_LAST)) begin
                    pressed      <= 1'b1;
                    rpt          <= '0;
                    rpt_periodic <= 1'b1;
                end else begin
                    rpt <= rpt + 1'b1;
                end
`endif
            end
        end

        assign out_btns[i]     = level;
        assign out_pressed[i]  = pressed;
        assign out_released[i] = released;
    end

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce
//
// Self-checking bench for btn_debounce with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3. A reference model tracks, per bit, the window of the last
// DEBOUNCE_CYCLES synchronized samples and the time held since an accepted
// press; directed scenarios add explicit latency and pulse-count checks, and a
// randomized run compares every cycle against the model.

module tb_btn_debounce;

    localparam int N  = 8;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic         clock   = 1'b0;
    logic         reset   = 1'b0;
    logic [N-1:0] in_btns = '0;
    logic [N-1:0] out_btns;
    logic [N-1:0] out_pressed;
    logic [N-1:0] out_released;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [N-1:0] m_s1       = '0;
    logic [N-1:0] m_s2       = '0;
    logic [N-1:0] m_level    = '0;
    logic [N-1:0] m_pressed  = '0;
    logic [N-1:0] m_released = '0;
    logic [N-1:0] m_hist[$];
    int           m_hold[N];

    always #5 clock = ~clock;

    btn_debounce #(
        .N(N),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_btns(in_btns),
        .out_btns(out_btns),
        .out_pressed(out_pressed),
        .out_released(out_released)
    );

    // Advance one clock edge and update the model from the inputs held across
    // that edge. A level is accepted once the last D synchronized samples all
    // disagree with it; repeats fire at hold time RD, RD+RP, RD+2RP, ...
    task automatic advance();
        logic         rst_v;
        logic [N-1:0] in_v;
        bit           all_diff;
        rst_v = reset;
        in_v  = in_btns;
        @(posedge clock);
        if (!rst_v) begin
            m_s1       = '0;
            m_s2       = '0;
            m_level    = '0;
            m_pressed  = '0;
            m_released = '0;
            m_hist.delete();
            for (int b = 0; b < N; b++) m_hold[b] = 0;
        end else begin
            m_hist.push_back(m_s2);
            if (m_hist.size() > D) void'(m_hist.pop_front());
            m_pressed  = '0;
            m_released = '0;
            for (int b = 0; b < N; b++) begin
                all_diff = (m_hist.size() == D);
                foreach (m_hist[j]) if (m_hist[j][b] == m_level[b]) all_diff = 1'b0;
                if (all_diff) begin
                    m_level[b] = !m_level[b];
                    if (m_level[b]) m_pressed[b] = 1'b1;
                    else            m_released[b] = 1'b1;
                    m_hold[b] = 0;
                end else if (AUTO && m_level[b]) begin
                    m_hold[b]++;
                    if (m_hold[b] == RD || (m_hold[b] > RD && (m_hold[b] - RD) % RP == 0))
                        m_pressed[b] = 1'b1;
                end
            end
            m_s2 = m_s1;
            m_s1 = in_v;
        end
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        in_btns = 8'hA5;
        repeat (2) begin
            advance();
            checks++;
            if (out_btns !== 8'h00 || out_pressed !== 8'h00 || out_released !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_outputs: got btns=%h pr=%h rl=%h, want 00 00 00",
                         out_btns, out_pressed, out_released);
            end
        end
    endtask

    task automatic test_clean_press();
        int rise;
        int npress;
        int nrel;
        reset   = 1'b1;
        in_btns = '0;
        repeat (3) begin
            advance();
            checks++;
            if (out_btns !== m_level || out_pressed !== m_pressed || out_released !== m_released) begin
                errors++;
                $display("[TB] FAIL press_idle: got %h %h %h, want %h %h %h",
                         out_btns, out_pressed, out_released, m_level, m_pressed, m_released);
            end
        end
        in_btns = 8'h01;
        rise = -1; npress = 0; nrel = 0;
        for (int n = 0; n < 12; n++) begin
            advance();
            checks++;
            if (out_btns !== m_level || out_pressed !== m_pressed || out_released !== m_released) begin
                errors++;
                $display("[TB] FAIL press_model n=%0d: got %h %h %h, want %h %h %h", n,
                         out_btns, out_pressed, out_released, m_level, m_pressed, m_released);
            end
            if (rise < 0 && out_btns[0]) rise = n;
            if (out_pressed != 0) npress++;
            if (out_released != 0) nrel++;
            if (n == D + 1) begin
                checks++;
                if (out_btns !== 8'h01 || out_pressed !== 8'h01 || out_released !== 8'h00) begin
                    errors++;
                    $display("[TB] FAIL press_edge: got %h %h %h, want 01 01 00",
                             out_btns, out_pressed, out_released);
                end
            end
        end
        checks++;
        if (rise != D + 1) begin
            errors++;
            $display("[TB] FAIL press_latency: got %0d edges, want %0d", rise, D + 1);
        end
        checks++;
        if (npress != 1 || nrel != 0) begin
            errors++;
            $display("[TB] FAIL press_pulses: got pressed=%0d released=%0d, want 1 0", npress, nrel);
        end
    endtask

    task automatic test_bounce();
        in_btns = '0;
        repeat (D + 4) begin
            advance();
            checks++;
            if (out_btns !== m_level || out_pressed !== m_pressed || out_released !== m_released) begin
                errors++;
                $display("[TB] FAIL bounce_settle: got %h %h %h, want %h %h %h",
                         out_btns, out_pressed, out_released, m_level, m_pressed, m_released);
            end
        end
        for (int p = 0; p < 5; p++) begin
            in_btns = (p < 4 && p % 2 == 0) ? 8'h01 : 8'h00;
            repeat ((p < 4) ? 3 : 10) begin
                advance();
                checks++;
                if (out_btns !== 8'h00 || out_pressed !== 8'h00 || out_released !== 8'h00 ||
                    out_btns !== m_level) begin
                    errors++;
                    $display("[TB] FAIL bounce_reject p=%0d: got %h %h %h, want 00 00 00",
                             p, out_btns, out_pressed, out_released);
                end
            end
        end
    endtask

    task automatic test_independent();
        in_btns = 8'h80;
        repeat (D + 4) begin
            advance();
            checks++;
            if (out_btns !== m_level || out_pressed !== m_pressed || out_released !== m_released) begin
                errors++;
                $display("[TB] FAIL indep_setup: got %h %h %h, want %h %h %h",
                         out_btns, out_pressed, out_released, m_level, m_pressed, m_released);
            end
        end
        in_btns = 8'h01;
        for (int n = 0; n < 8; n++) begin
            advance();
            checks++;
            if (out_btns !== m_level || out_pressed !== m_pressed || out_released !== m_released) begin
                errors++;
                $display("[TB] FAIL indep_model n=%0d: got %h %h %h, want %h %h %h", n,
                         out_btns, out_pressed, out_released, m_level, m_pressed, m_released);
            end
            if (n == D + 1) begin
                checks++;
                if (out_btns !== 8'h01 || out_pressed !== 8'h01 || out_released !== 8'h80) begin
                    errors++;
                    $display("[TB] FAIL indep_edge: got %h %h %h, want 01 01 80",
                             out_btns, out_pressed, out_released);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int rise;
        in_btns = '0;
        repeat (D + 4) advance();
        in_btns = 8'h01;
        repeat (4) advance();
        reset = 1'b0;
        repeat (2) begin
            advance();
            checks++;
            if (out_btns !== 8'h00 || out_pressed !== 8'h00 || out_released !== 8'h00) begin
                errors++;
                $display("[TB] FAIL midreset_quiet: got %h %h %h, want 00 00 00",
                         out_btns, out_pressed, out_released);
            end
        end
        reset = 1'b1;
        rise = -1;
        for (int n = 0; n < 10; n++) begin
            advance();
            checks++;
            if (out_btns !== m_level || out_pressed !== m_pressed || out_released !== m_released) begin
                errors++;
                $display("[TB] FAIL midreset_model n=%0d: got %h %h %h, want %h %h %h", n,
                         out_btns, out_pressed, out_released, m_level, m_pressed, m_released);
            end
            if (rise < 0 && out_btns[0]) rise = n;
        end
        checks++;
        if (rise != D + 1) begin
            errors++;
            $display("[TB] FAIL midreset_latency: got %0d edges, want %0d", rise, D + 1);
        end
    endtask

    task automatic test_held_reset();
        int full_pulses;
        int other_pulses;
        reset   = 1'b0;
        in_btns = 8'hFF;
        repeat (2) advance();
        reset = 1'b1;
        full_pulses = 0; other_pulses = 0;
        for (int n = 0; n < D + 7; n++) begin
            advance();
            checks++;
            if (out_btns !== m_level || out_pressed !== m_pressed || out_released !== m_released) begin
                errors++;
                $display("[TB] FAIL held_model n=%0d: got %h %h %h, want %h %h %h", n,
                         out_btns, out_pressed, out_released, m_level, m_pressed, m_released);
            end
            if (out_pressed == 8'hFF) full_pulses++;
            else if (out_pressed != 8'h00) other_pulses++;
        end
        checks++;
        if (out_btns !== 8'hFF || full_pulses != 1 || other_pulses != 0) begin
            errors++;
            $display("[TB] FAIL held_press: got btns=%h full=%0d partial=%0d, want FF 1 0",
                     out_btns, full_pulses, other_pulses);
        end
    endtask

    task automatic test_autorepeat();
        int exp_q[$];
        int got_q[$];
        int nrel;
        int npress_after;
        in_btns = '0;
        repeat (D + 4) advance();
        in_btns = 8'h04;
        for (int n = 0; n < 40; n++) begin
            advance();
            checks++;
            if (out_btns !== m_level || out_pressed !== m_pressed || out_released !== m_released) begin
                errors++;
                $display("[TB] FAIL repeat_model n=%0d: got %h %h %h, want %h %h %h", n,
                         out_btns, out_pressed, out_released, m_level, m_pressed, m_released);
            end
            if (out_pressed[2]) got_q.push_back(n);
        end
        exp_q.push_back(D + 1);
        if (AUTO) for (int t = D + 1 + RD; t < 40; t += RP) exp_q.push_back(t);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL repeat_count: got %0d pulses, want %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] != exp_q[k]) begin
                errors++;
                $display("[TB] FAIL repeat_time[%0d]: got edge %0d, want %0d", k, got_q[k], exp_q[k]);
            end
        end
        in_btns = '0;
        nrel = 0; npress_after = 0;
        for (int n = 0; n < 15; n++) begin
            advance();
            checks++;
            if (out_btns !== m_level || out_pressed !== m_pressed || out_released !== m_released) begin
                errors++;
                $display("[TB] FAIL release_model n=%0d: got %h %h %h, want %h %h %h", n,
                         out_btns, out_pressed, out_released, m_level, m_pressed, m_released);
            end
            if (nrel > 0 && out_pressed != 0) npress_after++;
            if (out_released == 8'h04) nrel++;
        end
        checks++;
        if (nrel != 1 || npress_after != 0) begin
            errors++;
            $display("[TB] FAIL release_pulses: got released=%0d later_pressed=%0d, want 1 0",
                     nrel, npress_after);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) != 0);
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 5) == 0) in_btns[b] = !in_btns[b];
            advance();
            checks++;
            if (out_btns !== m_level || out_pressed !== m_pressed || out_released !== m_released) begin
                errors++;
                $display("[TB] FAIL random_model n=%0d: got %h %h %h, want %h %h %h", n,
                         out_btns, out_pressed, out_released, m_level, m_pressed, m_released);
            end
            checks++;
            if ((out_pressed & out_released) !== 8'h00) begin
                errors++;
                $display("[TB] FAIL random_exclusive n=%0d: got overlap %h, want 00",
                         n, out_pressed & out_released);
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        for (int b = 0; b < N; b++) m_hold[b] = 0;
        $display("[TB] btn_debounce bench, autorepeat=%0d", AUTO);
        test_reset();
        test_clean_press();
        test_bounce();
        test_independent();
        test_reset_mid();
        test_held_reset();
        test_autorepeat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Input-side counterpart of the LED output path: conditions up to N raw push-button/switch inputs from board pins into clean, glitch-free levels plus single-cycle press/release events for design logic. Sits between the top-level `in_btns` pins and the main unit, in the same clock domain as the LED/VGA logic. Each bit has a two-flop synchronizer, a debounce counter and an edge detector. An optional auto-repeat feature is also provided per bit.

## Interface
- `N`, 8: number of button bits.
- `DEBOUNCE_CYCLES`, 250000: cycles a new level must persist before acceptance; ≥1 (10 ms at 25 MHz).
- `REPEAT_DELAY`, 12500000: cycles from accepted press to first repeat event (auto-repeat builds only); ≥1.
- `REPEAT_PERIOD`, 2500000: cycles between subsequent repeat events (auto-repeat builds only); ≥1.

- `clock` in 1: sole clock, all logic on rising edge.
- `reset` in 1: synchronous, active-low; sampled on rising edge of `clock`.
- `in_btns` in N: raw asynchronous button levels, 1 = pressed.
- `out_btns` out N: debounced level per bit.
- `out_pressed` out N: one-cycle pulse per bit on accepted 0→1 (and on repeats).
- `out_released` out N: one-cycle pulse per bit on accepted 1→0.

## Operation
- Reset (`reset`==0 at an edge): synchronizer flops, debounced levels, debounce counters and repeat counters all cleared; `out_btns`, `out_pressed`, `out_released` = 0 from the following cycle.
- Per bit i, fully independent; no shared state between bits.
- Synchronizer: `s1 <= in_btns[i]`, `s2 <= s1`; only `s2` is used downstream.
- Debounce counter `c` (width clog2(DEBOUNCE_CYCLES), min 1):
  - `s2 == out_btns[i]`: `c <= 0`.
  - `s2 != out_btns[i]` and `c < DEBOUNCE_CYCLES-1`: `c <= c+1`.
  - `s2 != out_btns[i]` and `c == DEBOUNCE_CYCLES-1`: `out_btns[i] <= s2`, `c <= 0`, assert `out_pressed[i]` (if s2=1) or `out_released[i]` (if s2=0) for exactly the next cycle.
- Any single cycle of agreement restarts the count from 0. Bounces shorter than DEBOUNCE_CYCLES never reach the outputs.
- `out_pressed`/`out_released` are registered, never both high on the same bit, and are cleared every cycle unless re-asserted.
- Button held through reset release: treated as a fresh press and reported normally after the debounce latency.
- Reset asserted mid-count: count is discarded with no partial event. Reset asserted during an output pulse: pulse drops on the next cycle.

## Timing
- Input level first captured by `s1` at edge k, held stable: `out_btns[i]` changes at edge k+1+DEBOUNCE_CYCLES. The event pulse is high in the cycle after that edge.
- With DEBOUNCE_CYCLES=1 the latency is 2 edges, pure synchronizer plus edge detect.
- Minimum spacing between two accepted edges on one bit: DEBOUNCE_CYCLES cycles.
- No combinational paths from inputs to outputs.

## Configuration
- `BTN_AUTOREPEAT_EN` defined: per-bit repeat counter `r`, cleared on every accepted edge and while `out_btns[i]`==0.
  - While held, `out_pressed[i]` pulses again when `r` reaches REPEAT_DELAY.
  - It then pulses every REPEAT_PERIOD cycles until release.
  - The release pulse and the clearing of `r` take precedence over a coincident repeat.
- Not defined: no repeat logic or counters are synthesized; REPEAT_* are ignored; `out_pressed` fires once per accepted press.

## Test plan
- Reset then clean press (DEBOUNCE_CYCLES=4): reset=0 for 2 edges, outputs 0; `in_btns`=0x01 captured at edge k → `out_btns`=0x01 at edge k+5, `out_pressed`=0x01 for one cycle, `out_released`=0.
- Bounce rejection (D=4): `in_btns[0]` toggles 1,0,1,0 with each level held 3 cycles, then rests at 0 → `out_btns` stays 0x00, no pulses.
- Independent bits: bit 0 pressed and bit 7 released on the same cycle from state 0x80 → 4+1 edges later `out_btns`=0x01, `out_pressed`=0x01 and `out_released`=0x80 in the same cycle.
- Reset mid-count: start a press, assert reset at count 2, release reset with input still 1 → no pulse during reset; press accepted D+1 edges after first post-reset capture.
- Held through reset: `in_btns`=0xFF during and after reset → `out_btns`=0xFF and `out_pressed`=0xFF exactly once.
- With `BTN_AUTOREPEAT_EN` (D=4, REPEAT_DELAY=10, REPEAT_PERIOD=3), hold bit 2 → pulses at press, +10, +13, +16 cycles. Release → one `out_released`=0x04 and no further `out_pressed`. Without the macro, the same stimulus gives a single press pulse.
